dma_xfer_counter: RTL and testbench
===================================

Name: dma_xfer_counter

Overview:
- Multi-channel address and word-count sequencer for the DMA engine.
- Generalises the single up/down counter into NCH independent channels, each holding source address, destination address and remaining-count registers.
- Per-channel modes: increment, decrement, fixed and increment-with-reload; 16- or 32-bit unit size; repeat with reload; terminal-count detection.
- Sits between the DMA register file (initial values and control) and the bus-transfer FSM, which issues one step per completed unit transfer.

Parameters:
- NCH, 4, number of channels.
- AW, 28, address width.
- CW, 16, count field width; a loaded count of 0 means 2^CW units.

Ports:
- clk  input  1  clock, posedge.
- rst_b  input  1  reset: rst_b, asynchronous, active-low; clock clk.
- sel  input  $clog2(NCH)  channel addressed by load/step/abort and by the read-out ports.
- load  input  1  start the selected channel with the init values.
- step  input  1  advance the selected channel by one unit.
- abort  input  1  stop the selected channel without a done pulse.
- src_init  input  AW  initial source address.
- dst_init  input  AW  initial destination address.
- cnt_init  input  CW  initial unit count.
- src_ctl  input  2  source mode: 00 inc, 01 dec, 10 fixed, 11 treated as inc.
- dst_ctl  input  2  destination mode: 00 inc, 01 dec, 10 fixed, 11 inc+reload.
- word32  input  1  1 = 4-byte units, 0 = 2-byte units.
- repeat_en  input  1  reload and continue at terminal count.
- src_addr  output  AW  source address of channel sel.
- dst_addr  output  AW  destination address of channel sel.
- remaining  output  CW+1  remaining units of channel sel.
- active  output  NCH  per-channel running flag.
- done  output  NCH  per-channel one-cycle terminal-count pulse.

Behaviour:
- Reset (async, rst_b=0): all address and count registers, latched controls, active and done = 0. Reset mid-transfer drops state immediately; no done pulse is produced.
- Per channel the state is IDLE (active=0) or RUN (active=1). All state updates occur on the clk edge.
- load (any state): latch src_init, dst_init, cnt_init, src_ctl, dst_ctl, word32 and repeat_en; enter RUN.
  - Alignment: word32=1 clears address bits [1:0]; word32=0 clears bit [0].
  - remaining = (cnt_init==0) ? 2^CW : cnt_init.
  - Latched copies of dst_init and cnt_init are kept for reload.
- step in RUN:
  - Addresses move by size = word32 ? 4 : 2 according to their ctl field (inc +size, dec -size, fixed unchanged), modulo 2^AW.
  - remaining decrements by 1.
- step in IDLE: ignored, no state change.
- Terminal count: a step while remaining==1.
  - The channel's done bit is 1 during the next cycle only (registered).
  - Addresses advance as for a normal step.
  - If latched repeat=1: remaining reloads from the latched count (0 maps to 2^CW); dst reloads from the latched dst_init only when dst_ctl==11; channel stays RUN.
  - If repeat=0: remaining becomes 0 and the channel enters IDLE. Addresses hold their final values.
- abort: selected channel enters IDLE and keeps its registers; no done pulse.
- Priority on the selected channel when asserted together: load > abort > step.
- Only channel sel is affected by load, step or abort; every other channel holds its state.
- src_addr, dst_addr and remaining are combinational muxes of channel sel's registers (zero latency); active is a direct register output.
- A step on a channel in the same cycle as its done pulse is legal and is processed normally.

Test Plan:
- Reset: rst_b low, then release → active=0, done=0, remaining=0 and both addresses 0 for every sel.
- Ch0 load src=0x100, dst=0x200, cnt=3, inc/inc, word32=1, repeat=0, then 3 steps → src 0x104/0x108/0x10C, dst 0x204/0x208/0x20C; done[0]=1 exactly one cycle after the 3rd step; active[0]=0.
- Ch1 load src=0x103, dst=0x50, src_ctl=01, dst_ctl=10, word32=0, cnt=2, then 2 steps → src aligned to 0x102, then 0x100, 0x0FE; dst stays 0x50.
- Ch3 cnt=0, CW=16 → remaining=0x10000 after load; 0x10000 steps then produce done; src decrementing from 0x0 wraps to 0xFFFFFFC (AW=28, word32=1).
- Ch2 dst_ctl=11, repeat=1, cnt=2, dst=0x400, word32=1, then 2 steps → done pulse; dst back to 0x400, remaining=2, active[2] stays 1.
- Collisions:
  - load+step same cycle → load values only, with no advance.
  - abort mid-run → active=0 and no done pulse.
  - step on ch1 while ch0 is running → ch0 registers unchanged.
  - rst_b asserted mid-run → all state cleared asynchronously.

Source files
------------

// File: rtl/dma_xfer_counter.sv
// Multi-channel DMA address / word-count sequencer: per channel, source and
// destination address generators plus a remaining-unit counter with reload.
module dma_xfer_counter #(
    parameter int NCH = 4,
    parameter int AW  = 28,
    parameter int CW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     load,
    input  logic                     step,
    input  logic                     abort,
    input  logic [AW-1:0]            src_init,
    input  logic [AW-1:0]            dst_init,
    input  logic [CW-1:0]            cnt_init,
    input  logic [1:0]               src_ctl,
    input  logic [1:0]               dst_ctl,
    input  logic                     word32,
    input  logic                     repeat_en,
    output logic [AW-1:0]            src_addr,
    output logic [AW-1:0]            dst_addr,
    output logic [CW:0]              remaining,
    output logic [NCH-1:0]           active,
    output logic [NCH-1:0]           done
);

    localparam int SW = $clog2(NCH);

    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a, input logic w32);
        logic [AW-1:0] mask;
        if (w32) begin
            mask = {{(AW-2){1'b1}}, 2'b00};
        end else begin
            mask = {{(AW-1){1'b1}}, 1'b0};
        end
        return a & mask;
    endfunction

    // A zero count encodes the full 2^CW range.
    function automatic logic [CW:0] expand_count(input logic [CW-1:0] c);
        if (c == {CW{1'b0}}) begin
            return {1'b1, {CW{1'b0}}};
        end else begin
            return {1'b0, c};
        end
    endfunction

    // Mode 11 behaves as increment for the address move itself; the dst
    // reload flavour is handled at terminal count.
    function automatic logic [AW-1:0] move_addr(input logic [AW-1:0] a, input logic [1:0] ctl,
                                                input logic w32);
        logic [AW-1:0] size;
        size = w32 ? AW'(3'd4) : AW'(3'd2);
        case (ctl)
            2'b01:   return a - size;
            2'b10:   return a;
            default: return a + size;
        endcase
    endfunction

    logic [NCH-1:0][AW-1:0] w_src_all;
    logic [NCH-1:0][AW-1:0] w_dst_all;
    logic [NCH-1:0][CW:0]   w_rem_all;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [AW-1:0] r_src;
        logic [AW-1:0] r_dst;
        logic [AW-1:0] r_dst_init;
        logic [CW-1:0] r_cnt_init;
        logic [CW:0]   r_rem;
        logic [1:0]    r_src_ctl;
        logic [1:0]    r_dst_ctl;
        logic          r_w32;
        logic          r_rep;
        logic          r_active;
        logic          r_done;

        logic          w_hit;
        logic          w_load;
        logic          w_abort;
        logic          w_step;
        logic          w_tc;
        logic [AW-1:0] w_src_mv;
        logic [AW-1:0] w_dst_mv;
        logic [AW-1:0] w_src_nxt;
        logic [AW-1:0] w_dst_nxt;
        logic [CW:0]   w_rem_nxt;
        logic          w_active_nxt;

        // Command decode with load > abort > step priority; idle steps are dropped.
        assign w_hit    = (sel == SW'(c));
        assign w_load   = w_hit & load;
        assign w_abort  = w_hit & abort & ~load;
        assign w_step   = w_hit & step & ~load & ~abort & r_active;
        assign w_tc     = w_step & (r_rem == (CW+1)'(1));
        assign w_src_mv = move_addr(r_src, r_src_ctl, r_w32);
        assign w_dst_mv = move_addr(r_dst, r_dst_ctl, r_w32);

        // Next-state selection for the channel's address, count and run flag.
        always_comb begin
            w_src_nxt    = r_src;
            w_dst_nxt    = r_dst;
            w_rem_nxt    = r_rem;
            w_active_nxt = r_active;
            if (w_load) begin
                w_src_nxt    = align_addr(src_init, word32);
                w_dst_nxt    = align_addr(dst_init, word32);
                w_rem_nxt    = expand_count(cnt_init);
                w_active_nxt = 1'b1;
            end else if (w_abort) begin
                w_active_nxt = 1'b0;
            end else if (w_step) begin
                w_src_nxt = w_src_mv;
                if (w_tc) begin
                    if (r_rep) begin
                        w_rem_nxt = expand_count(r_cnt_init);
                        w_dst_nxt = (r_dst_ctl == 2'b11) ? r_dst_init : w_dst_mv;
                    end else begin
                        w_rem_nxt    = {(CW+1){1'b0}};
                        w_dst_nxt    = w_dst_mv;
                        w_active_nxt = 1'b0;
                    end
                end else begin
                    w_rem_nxt = r_rem - (CW+1)'(1);
                    w_dst_nxt = w_dst_mv;
                end
            end else begin
                w_active_nxt = r_active;
            end
        end

        // Channel state registers; controls and reload copies latch on load.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                r_src      <= {AW{1'b0}};
                r_dst      <= {AW{1'b0}};
                r_dst_init <= {AW{1'b0}};
                r_cnt_init <= {CW{1'b0}};
                r_rem      <= {(CW+1){1'b0}};
                r_src_ctl  <= 2'b00;
                r_dst_ctl  <= 2'b00;
                r_w32      <= 1'b0;
                r_rep      <= 1'b0;
                r_active   <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                r_src    <= w_src_nxt;
                r_dst    <= w_dst_nxt;
                r_rem    <= w_rem_nxt;
                r_active <= w_active_nxt;
                r_done   <= w_tc;
                if (w_load) begin
                    r_dst_init <= align_addr(dst_init, word32);
                    r_cnt_init <= cnt_init;
                    r_src_ctl  <= src_ctl;
                    r_dst_ctl  <= dst_ctl;
                    r_w32      <= word32;
                    r_rep      <= repeat_en;
                end
            end
        end

        assign w_src_all[c] = r_src;
        assign w_dst_all[c] = r_dst;
        assign w_rem_all[c] = r_rem;
        assign active[c]    = r_active;
        assign done[c]      = r_done;
    end

    assign src_addr  = w_src_all[sel];
    assign dst_addr  = w_dst_all[sel];
    assign remaining = w_rem_all[sel];

endmodule

// File: tb/tb_dma_xfer_counter.sv
// Scoreboard bench for dma_xfer_counter: expected outputs are queued per
// stimulus cycle and popped against the DUT after the edge.
module tb_dma_xfer_counter;
    localparam int NCH = 4;
    localparam int AW  = 28;
    localparam int CW  = 16;

    logic             clk = 1'b0;
    logic             rst_b = 1'b1;
    logic [1:0]       sel = 2'd0;
    logic             load = 1'b0, step = 1'b0, abort = 1'b0;
    logic [AW-1:0]    src_init = '0, dst_init = '0;
    logic [CW-1:0]    cnt_init = '0;
    logic [1:0]       src_ctl = 2'b00, dst_ctl = 2'b00;
    logic             word32 = 1'b0, repeat_en = 1'b0;
    logic [AW-1:0]    src_addr, dst_addr;
    logic [CW:0]      remaining;
    logic [NCH-1:0]   active, done;

    dma_xfer_counter #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_b(rst_b), .sel(sel), .load(load), .step(step), .abort(abort),
        .src_init(src_init), .dst_init(dst_init), .cnt_init(cnt_init),
        .src_ctl(src_ctl), .dst_ctl(dst_ctl), .word32(word32), .repeat_en(repeat_en),
        .src_addr(src_addr), .dst_addr(dst_addr), .remaining(remaining),
        .active(active), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum int {K_SRC, K_DST, K_REM, K_ACT, K_DONE} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_SRC:   return 32'(src_addr);
            K_DST:   return 32'(dst_addr);
            K_REM:   return 32'(remaining);
            K_ACT:   return 32'(active);
            default: return 32'(done);
        endcase
    endfunction

    task automatic sb_push(kind_t k, logic [31:0] v, string n);
        sbq.push_back('{k, v, n});
    endtask

    task automatic cfg(logic [31:0] s, logic [31:0] d, logic [31:0] cnt, logic [1:0] sc,
                       logic [1:0] dc, logic w, logic rp);
        src_init = AW'(s); dst_init = AW'(d); cnt_init = CW'(cnt);
        src_ctl = sc; dst_ctl = dc; word32 = w; repeat_en = rp;
    endtask

    task automatic cyc(logic ld, logic st, logic ab);
        load = ld; step = st; abort = ab;
        @(posedge clk);
        #1;
        load = 1'b0; step = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        #2 rst_b = 1'b0;
        #10;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                sel = 2'(k); #1;
                sb_push(K_SRC, 32'h0, "rst_src"); sb_push(K_DST, 32'h0, "rst_dst");
                sb_push(K_REM, 32'h0, "rst_rem");
            end else if (k == 4) begin
                sb_push(K_ACT, 32'h0, "rst_active"); sb_push(K_DONE, 32'h0, "rst_done");
            end else begin
                @(negedge clk); rst_b = 1'b1; cyc(1'b0, 1'b0, 1'b0);
                sb_push(K_ACT, 32'h0, "post_rst_active"); sb_push(K_DONE, 32'h0, "post_rst_done");
            end
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_inc_ch0();
        exp_t e; logic [31:0] o;
        sel = 2'd0; cfg(32'h100, 32'h200, 32'd3, 2'b00, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                cyc(1'b1, 1'b0, 1'b0);
                sb_push(K_SRC, 32'h100, "inc_load_src"); sb_push(K_DST, 32'h200, "inc_load_dst");
                sb_push(K_REM, 32'd3, "inc_load_rem"); sb_push(K_ACT, 32'h1, "inc_load_act");
            end else if (k <= 3) begin
                cyc(1'b0, 1'b1, 1'b0);
                sb_push(K_SRC, 32'h100 + 32'(4*k), "inc_src"); sb_push(K_DST, 32'h200 + 32'(4*k), "inc_dst");
                sb_push(K_REM, 32'(3-k), "inc_rem");
                sb_push(K_DONE, (k == 3) ? 32'h1 : 32'h0, "inc_done");
                sb_push(K_ACT, (k == 3) ? 32'h0 : 32'h1, "inc_act");
            end else if (k == 4) begin
                cyc(1'b0, 1'b0, 1'b0);
                sb_push(K_DONE, 32'h0, "inc_done_one_cycle"); sb_push(K_ACT, 32'h0, "inc_idle_act");
            end else begin
                cyc(1'b0, 1'b1, 1'b0);
                sb_push(K_SRC, 32'h10C, "idle_step_src"); sb_push(K_REM, 32'h0, "idle_step_rem");
                sb_push(K_DONE, 32'h0, "idle_step_done");
            end
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_dec_fixed_ch1();
        exp_t e; logic [31:0] o;
        sel = 2'd1; cfg(32'h103, 32'h50, 32'd2, 2'b01, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(k == 0, k != 0, 1'b0);
            sb_push(K_SRC, 32'h102 - 32'(2*k), "dec_src"); sb_push(K_DST, 32'h50, "fixed_dst");
            sb_push(K_REM, 32'(2-k), "dec_rem");
            sb_push(K_DONE, (k == 2) ? 32'h2 : 32'h0, "dec_done");
            sb_push(K_ACT, (k == 2) ? 32'h0 : 32'h2, "dec_act");
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_repeat_ch2();
        exp_t e; logic [31:0] o;
        sel = 2'd2; cfg(32'h800, 32'h400, 32'd2, 2'b00, 2'b11, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin
                    cyc(1'b1, 1'b0, 1'b0);
                    sb_push(K_DST, 32'h400, "rep_load_dst"); sb_push(K_REM, 32'd2, "rep_load_rem");
                    sb_push(K_ACT, 32'h4, "rep_load_act");
                end
                1: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'h804, "rep_src1"); sb_push(K_DST, 32'h404, "rep_dst1");
                    sb_push(K_REM, 32'd1, "rep_rem1"); sb_push(K_DONE, 32'h0, "rep_done1");
                end
                2: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'h808, "rep_src_tc"); sb_push(K_DST, 32'h400, "rep_dst_reload");
                    sb_push(K_REM, 32'd2, "rep_rem_reload"); sb_push(K_DONE, 32'h4, "rep_done_tc");
                    sb_push(K_ACT, 32'h4, "rep_act_stays");
                end
                3: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'h80C, "rep_src_during_done"); sb_push(K_DST, 32'h404, "rep_dst_during_done");
                    sb_push(K_REM, 32'd1, "rep_rem_during_done"); sb_push(K_DONE, 32'h0, "rep_done_drop");
                end
                4: begin
                    cyc(1'b0, 1'b1, 1'b1);
                    sb_push(K_ACT, 32'h0, "abort_act"); sb_push(K_REM, 32'd1, "abort_over_step_rem");
                    sb_push(K_DST, 32'h404, "abort_keep_dst"); sb_push(K_DONE, 32'h0, "abort_no_done");
                end
                default: begin
                    cyc(1'b0, 1'b0, 1'b0);
                    sb_push(K_DONE, 32'h0, "abort_no_late_done"); sb_push(K_ACT, 32'h0, "abort_idle_act");
                end
            endcase
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_wrap_ch3();
        exp_t e; logic [31:0] o;
        sel = 2'd3; cfg(32'h0, 32'h0, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    cyc(1'b1, 1'b0, 1'b0);
                    sb_push(K_REM, 32'h10000, "zero_cnt_rem"); sb_push(K_SRC, 32'h0, "wrap_load_src");
                    sb_push(K_ACT, 32'h8, "wrap_load_act");
                end
                1: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'hFFFFFFC, "wrap_src"); sb_push(K_DST, 32'h4, "wrap_dst1");
                    sb_push(K_REM, 32'hFFFF, "wrap_rem1");
                end
                2: begin
                    step = 1'b1;
                    repeat (65534) @(posedge clk);
                    #1 step = 1'b0;
                    sb_push(K_REM, 32'd1, "long_run_rem"); sb_push(K_ACT, 32'h8, "long_run_act");
                    sb_push(K_DONE, 32'h0, "long_run_no_done");
                end
                3: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_DONE, 32'h8, "long_run_done"); sb_push(K_ACT, 32'h0, "long_run_idle");
                    sb_push(K_REM, 32'h0, "long_run_rem0"); sb_push(K_SRC, 32'hFFC0000, "long_run_src");
                    sb_push(K_DST, 32'h40000, "long_run_dst");
                end
                default: begin
                    cyc(1'b0, 1'b0, 1'b0);
                    sb_push(K_DONE, 32'h0, "long_run_done_clear");
                end
            endcase
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_collisions();
        exp_t e; logic [31:0] o;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin
                    sel = 2'd0; cfg(32'h1000, 32'h2000, 32'd5, 2'b00, 2'b00, 1'b1, 1'b0);
                    cyc(1'b1, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'h1000, "ldstep_src"); sb_push(K_DST, 32'h2000, "ldstep_dst");
                    sb_push(K_REM, 32'd5, "ldstep_rem"); sb_push(K_ACT, 32'h1, "ldstep_act");
                end
                1: begin
                    sel = 2'd1; cfg(32'h300, 32'h600, 32'd4, 2'b00, 2'b00, 1'b0, 1'b0);
                    cyc(1'b1, 1'b0, 1'b0);
                    sb_push(K_SRC, 32'h300, "ch1_load_src"); sb_push(K_ACT, 32'h3, "two_active");
                end
                2: begin
                    cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_SRC, 32'h302, "ch1_step_src"); sb_push(K_DST, 32'h602, "ch1_step_dst");
                    sb_push(K_REM, 32'd3, "ch1_step_rem");
                end
                3: begin
                    sel = 2'd0; cyc(1'b0, 1'b0, 1'b0);
                    sb_push(K_SRC, 32'h1000, "ch0_isolated_src"); sb_push(K_DST, 32'h2000, "ch0_isolated_dst");
                    sb_push(K_REM, 32'd5, "ch0_isolated_rem");
                end
                4: begin
                    cyc(1'b0, 1'b1, 1'b1);
                    sb_push(K_ACT, 32'h2, "abort_mid_act"); sb_push(K_SRC, 32'h1000, "abort_mid_src");
                    sb_push(K_DONE, 32'h0, "abort_mid_done");
                end
                default: begin
                    cfg(32'h1100, 32'h2100, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0);
                    cyc(1'b1, 1'b0, 1'b1);
                    sb_push(K_ACT, 32'h3, "load_over_abort_act"); sb_push(K_SRC, 32'h1100, "load_over_abort_src");
                    sb_push(K_REM, 32'd1, "load_over_abort_rem");
                end
            endcase
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e; logic [31:0] o;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    sel = 2'd0; cyc(1'b0, 1'b1, 1'b0);
                    sb_push(K_DONE, 32'h1, "pre_rst_done"); sb_push(K_ACT, 32'h2, "pre_rst_act");
                end
                1: begin
                    rst_b = 1'b0; #2;
                    sb_push(K_ACT, 32'h0, "async_rst_act"); sb_push(K_DONE, 32'h0, "async_rst_done");
                    sb_push(K_SRC, 32'h0, "async_rst_src0"); sb_push(K_DST, 32'h0, "async_rst_dst0");
                    sb_push(K_REM, 32'h0, "async_rst_rem0");
                end
                2: begin
                    sel = 2'd1; #1;
                    sb_push(K_SRC, 32'h0, "async_rst_src1"); sb_push(K_REM, 32'h0, "async_rst_rem1");
                end
                default: begin
                    @(negedge clk); rst_b = 1'b1; cyc(1'b0, 1'b0, 1'b0);
                    sb_push(K_ACT, 32'h0, "after_rst_act"); sb_push(K_DONE, 32'h0, "after_rst_done");
                end
            endcase
            while (sbq.size() != 0) begin
                e = sbq.pop_front(); o = observe(e.kind); n_cmp++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_ch0();
        test_dec_fixed_ch1();
        test_repeat_ch2();
        test_wrap_ch3();
        test_collisions();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
